// File: rtl/stack_ram_responder_if.sv
// Request/response bundle between the CPU control FSM (master) and the stack/instruction RAM responder (slave).
// Bursts are packed MSB-first: word i occupies bits [255-16i -: 16].
interface stack_ram_responder_if;
  logic         read_start;
  logic         write_start;
  logic [15:0]  address;
  logic [15:0]  words;
  logic [255:0] write_data;
  logic [255:0] read_data;
  logic         read_done;
  logic         write_done;
  logic         busy;
  logic         error;

  modport master (
    output read_start, write_start, address, words, write_data,
    input  read_data, read_done, write_done, busy, error
  );

  modport slave (
    input  read_start, write_start, address, words, write_data,
    output read_data, read_done, write_done, busy, error
  );
endinterface

// File: rtl/stack_ram_responder.sv
// Word-addressed 16-bit RAM serving CPU read/write bursts, one word per clock, with level start/done handshakes.
// Optional STACK_RAM_BOUNDS_CHECK_EN: reject bursts running past DEPTH and flag error instead of wrapping.
module stack_ram_responder #(
  parameter int DEPTH     = 1024,
  parameter int MAX_WORDS = 16
) (
  input logic                  clock,
  input logic                  reset,
  stack_ram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t         state, state_nxt;
  logic           is_read_q;
  logic [EW-1:0]  eff_q;
  logic [EW-1:0]  idx_q;
  logic [15:0]    addr_q;
  logic [255:0]   wdata_q;
  logic [255:0]   rdata_q;
  logic [15:0]    mem [DEPTH];

  logic           accept_rd, accept_wr, accept;
  logic           active_start;
  logic           xfer;
  logic           fault_in;
  logic [EW-1:0]  eff_in;
  logic [AW-1:0]  ram_idx;
  logic [7:0]     lane_base;

  function automatic logic [EW-1:0] clamp_len(input logic [15:0] w);
    if (w > 16'(MAX_WORDS)) return EW'(MAX_WORDS);
    return w[EW-1:0];
  endfunction

  assign accept_rd    = (state == IDLE) && bus.read_start;
  assign accept_wr    = (state == IDLE) && !bus.read_start && bus.write_start;
  assign accept       = accept_rd || accept_wr;
  assign eff_in       = clamp_len(bus.words);
  assign active_start = is_read_q ? bus.read_start : bus.write_start;
  assign xfer         = ((state == READ) || (state == WRITE)) && active_start && (idx_q != eff_q);
  // Address arithmetic truncates to AW bits, so bursts wrap around the end of the array.
  assign ram_idx      = AW'(addr_q + 16'(idx_q));
  assign lane_base    = 8'd255 - (8'(idx_q) << 4);

`ifdef STACK_RAM_BOUNDS_CHECK_EN
  assign fault_in = (17'(bus.address) + 17'(eff_in)) > 17'(DEPTH);
`else
  assign fault_in = 1'b0;
`endif

  // State register and control/response state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      is_read_q <= 1'b0;
      eff_q     <= '0;
      idx_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_read_q <= accept_rd;
        eff_q     <= eff_in;
        idx_q     <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + EW'(1);
      end
      if (accept_rd)
        rdata_q <= '0;
      else if (xfer && is_read_q)
        rdata_q[lane_base -: 16] <= mem[ram_idx];
    end
  end

  // Request payload captured at accept; never reset
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q  <= bus.address;
      wdata_q <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (xfer && !is_read_q)
      mem[ram_idx] <= wdata_q[lane_base -: 16];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.read_start)       state_nxt = fault_in ? DONE : READ;
        else if (bus.write_start) state_nxt = fault_in ? DONE : WRITE;
      end
      READ, WRITE: begin
        // Dropping start mid-burst aborts without ever raising done.
        if (!active_start)        state_nxt = IDLE;
        else if (idx_q == eff_q)  state_nxt = DONE;
      end
      DONE: begin
        if (!active_start)        state_nxt = IDLE;
      end
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.read_done  = (state == DONE) && is_read_q;
    bus.write_done = (state == DONE) && !is_read_q;
    bus.busy       = (state != IDLE);
    bus.read_data  = rdata_q;
  end

`ifdef STACK_RAM_BOUNDS_CHECK_EN
  logic error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       error_q <= 1'b0;
    else if (accept) error_q <= fault_in;
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_stack_ram_responder.sv
// Randomized and directed bench for stack_ram_responder against an array model of the RAM and burst timing rules.
module tb_stack_ram_responder;
  localparam int DEPTH = 1024;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] mem_m [DEPTH];

  stack_ram_responder_if bus ();

  stack_ram_responder #(.DEPTH(DEPTH), .MAX_WORDS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic int clamp(input int n);
    return (n > 16) ? 16 : n;
  endfunction

  function automatic logic [255:0] model_read(input int addr, input int n);
    logic [255:0] v = '0;
    for (int i = 0; i < clamp(n); i++) v[255-16*i -: 16] = mem_m[(addr + i) % DEPTH];
    return v;
  endfunction

  task automatic model_write(input int addr, input int n, input logic [255:0] wd);
    for (int i = 0; i < n; i++) mem_m[(addr + i) % DEPTH] = wd[255-16*i -: 16];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 256'(bus.busy), 256'(0));
    check({tag, "_rdone"}, 256'(bus.read_done), 256'(0));
    check({tag, "_wdone"}, 256'(bus.write_done), 256'(0));
  endtask

  // Full burst: accept, wait bounded for done, check latency/data, hold, release.
  task automatic do_xfer(input bit rd, input int addr, input int n, input logic [255:0] wd, input string tag);
    int   eff = clamp(n);
    int   k = 0;
    logic got_done = 1'b0;
    bus.read_start  = rd;
    bus.write_start = !rd;
    bus.address     = addr[15:0];
    bus.words       = n[15:0];
    bus.write_data  = wd;
    tick();
    while (!got_done && k < eff + 4) begin
      tick();
      k++;
      got_done = rd ? bus.read_done : bus.write_done;
    end
    check({tag, "_lat"}, 256'(k), 256'(eff + 1));
    check({tag, "_err"}, 256'(bus.error), 256'(0));
    if (rd) check({tag, "_data"}, bus.read_data, model_read(addr, n));
    else    model_write(addr, eff, wd);
    tick();
    check({tag, "_hold"}, 256'(rd ? bus.read_done : bus.write_done), 256'(1));
    bus.read_start  = 1'b0;
    bus.write_start = 1'b0;
    tick();
    check_idle({tag, "_rel"});
  endtask

  initial begin
    logic [255:0] wd;
    int           a, n, k;
    logic         got;

    reset           = 1'b0;
    bus.read_start  = 1'b0;
    bus.write_start = 1'b0;
    bus.address     = '0;
    bus.words       = '0;
    bus.write_data  = '0;
    #3 reset = 1'b1;
    #4;
    check_idle("reset");
    check("reset_rdata", bus.read_data, '0);
    check("reset_error", 256'(bus.error), 256'(0));
    tick();
    reset = 1'b0;
    tick();

    for (int b = 0; b < DEPTH / 16; b++) do_xfer(1'b0, b * 16, 16, rand256(), "fill");

    wd = '0;
    wd[255:240] = 16'h1234;
    do_xfer(1'b0, 5, 1, wd, "wr5");
    do_xfer(1'b1, 5, 1, '0, "rd5");

    for (int i = 0; i < 16; i++) wd[255-16*i -: 16] = 16'(i + 1);
    do_xfer(1'b0, 0, 16, wd, "wr16");
    do_xfer(1'b1, 0, 16, '0, "rd16");

    // Simultaneous requests: read first, write only in the IDLE after read_done drops.
    wd = rand256();
    bus.read_start  = 1'b1;
    bus.write_start = 1'b1;
    bus.address     = 16'd100;
    bus.words       = 16'd2;
    bus.write_data  = wd;
    tick();
    k = 0; got = 1'b0;
    while (!got && k < 8) begin tick(); k++; got = bus.read_done; end
    check("both_rd_lat", 256'(k), 256'(3));
    check("both_wdone", 256'(bus.write_done), 256'(0));
    check("both_rdata", bus.read_data, model_read(100, 2));
    bus.read_start = 1'b0;
    tick();
    check("both_gap_busy", 256'(bus.busy), 256'(0));
    tick();
    check("both_wr_busy", 256'(bus.busy), 256'(1));
    k = 0; got = 1'b0;
    while (!got && k < 8) begin tick(); k++; got = bus.write_done; end
    check("both_wr_lat", 256'(k), 256'(3));
    model_write(100, 2, wd);
    bus.write_start = 1'b0;
    tick();
    check_idle("both_rel");
    do_xfer(1'b1, 100, 2, '0, "both_rb");

    do_xfer(1'b0, DEPTH - 1, 2, rand256(), "wrap_wr");
    do_xfer(1'b1, DEPTH - 1, 2, '0, "wrap_rd");
    do_xfer(1'b1, 0, 1, '0, "wrap_rd0");

    // Read aborted after three transfer edges.
    bus.read_start = 1'b1;
    bus.address    = 16'd300;
    bus.words      = 16'd8;
    tick();
    repeat (3) tick();
    bus.read_start = 1'b0;
    tick();
    check_idle("rd_abort");
    do_xfer(1'b1, 300, 8, '0, "rd_after_abort");

    // Write aborted after three words land.
    wd = rand256();
    bus.write_start = 1'b1;
    bus.address     = 16'd200;
    bus.words       = 16'd8;
    bus.write_data  = wd;
    tick();
    repeat (3) tick();
    bus.write_start = 1'b0;
    tick();
    check_idle("wr_abort");
    model_write(200, 3, wd);
    do_xfer(1'b1, 200, 8, '0, "wr_abort_rb");

    // Reset mid-burst after four words are written.
    wd = rand256();
    bus.write_start = 1'b1;
    bus.address     = 16'd400;
    bus.words       = 16'd16;
    bus.write_data  = wd;
    tick();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check_idle("rst_mid");
    check("rst_mid_rdata", bus.read_data, '0);
    bus.write_start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    model_write(400, 4, wd);
    do_xfer(1'b1, 400, 16, '0, "rst_rb");

    do_xfer(1'b1, 50, 0, '0, "rd_zero");
    do_xfer(1'b0, 50, 0, rand256(), "wr_zero");
    do_xfer(1'b1, 50, 1, '0, "zero_rb");
    do_xfer(1'b0, 600, 40, rand256(), "wr_clamp");
    do_xfer(1'b1, 600, 40, '0, "rd_clamp");

    for (int t = 0; t < 40; t++) begin
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 20);
      do_xfer(1'($urandom_range(0, 1)), a, n, rand256(), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
